// File: rtl/x_scope_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : x_scope_dump_pkg
// Description : Shared types and defaults for the scope readout controller.
// Revision    : 1.0 - initial release
// ============================================================================
package x_scope_dump_pkg;

  localparam int unsigned DEF_ADDR_W     = 11;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_CNT_W      = 12;
  localparam int unsigned DEF_RD_LAT     = 1;
  localparam int unsigned BYTES_PER_WORD = DEF_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5
  } state_t;

  // Index width for a counter that must hold values 0..n-1 (never below 1 bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/x_word_ser.sv
`default_nettype none
// ============================================================================
// Module      : x_word_ser
// Description : Loads one DATA_W word and emits it byte by byte, LSB first,
//               over a valid/accept handshake. Flags the final byte.
// Revision    : 1.0 - initial release
// ============================================================================
module x_word_ser
  import x_scope_dump_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_accept,
  output logic              o_valid,
  output logic [7:0]        o_data,
  output logic              o_last,
  output logic              o_xfer
);

  localparam int unsigned          BPW      = DATA_W / 8;
  localparam int unsigned          IDX_W    = idx_width(BPW);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(BPW - 1);

  logic [DATA_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q,  idx_d;
  logic              valid_q, valid_d;

  assign o_valid = valid_q;
  assign o_data  = word_q[7:0];
  assign o_last  = valid_q && (idx_q == LAST_IDX);
  // Accept only has meaning while a byte is actually on offer.
  assign o_xfer  = valid_q && i_accept;

  // Shift register advances one byte per accepted transfer; drops valid after the last.
  always_comb begin
    word_d  = word_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (i_load) begin
      word_d  = i_word;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (o_xfer) begin
      if (idx_q == LAST_IDX) begin
        valid_d = 1'b0;
      end else begin
        word_d = word_q >> 8;
        idx_d  = idx_q + IDX_W'(1);
      end
    end
  end

  // State register; reset abandons any partially sent word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/x_scope_dump.sv
`default_nettype none
// ============================================================================
// Module      : x_scope_dump
// Description : Autonomous readout of a window of scope capture RAM, streamed
//               byte-serially to a UART transmitter.
//               Optional macro X_SCOPE_DUMP_CSUM_EN appends an XOR checksum
//               byte after the last data byte of a non-empty dump.
// Revision    : 1.0 - initial release
// ============================================================================
module x_scope_dump
  import x_scope_dump_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned RD_LAT = DEF_RD_LAT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [CNT_W-1:0]  i_count,
  input  logic              i_scope_busy,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ren,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_accept
);

  localparam int unsigned          LAT_W    = idx_width(RD_LAT);
  localparam logic [LAT_W-1:0]     LAT_LAST = LAT_W'(RD_LAT - 1);
  localparam longint unsigned      MAX_CNT  = longint'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [LAT_W-1:0]  lat_q,   lat_d;
`ifdef X_SCOPE_DUMP_CSUM_EN
  logic [7:0]        csum_q,  csum_d;
`endif

  logic              ser_load;
  logic              ser_valid;
  logic [7:0]        ser_data;
  logic              ser_last;
  logic              ser_xfer;

  x_word_ser #(
    .DATA_W (DATA_W)
  ) u_word_ser (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (ser_load),
    .i_word   (i_rdata),
    .i_accept (i_tx_accept),
    .o_valid  (ser_valid),
    .o_data   (ser_data),
    .o_last   (ser_last),
    .o_xfer   (ser_xfer)
  );

  // Sequencing: latch the window on start, then read/wait/send each word in turn.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    ser_load = 1'b0;
`ifdef X_SCOPE_DUMP_CSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_start && !i_scope_busy) begin
          addr_d = i_base;
          // A window larger than the RAM would only re-read the same words.
          if (64'(i_count) > MAX_CNT) begin
            cnt_d = CNT_W'(MAX_CNT);
          end else begin
            cnt_d = i_count;
          end
          lat_d   = '0;
`ifdef X_SCOPE_DUMP_CSUM_EN
          csum_d  = '0;
`endif
          state_d = READ;
        end
      end
      READ: begin
        // An empty window passes through here without a read and finishes.
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          lat_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == LAT_LAST) begin
          ser_load = 1'b1;
          state_d  = SEND;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      SEND: begin
        if (ser_xfer) begin
`ifdef X_SCOPE_DUMP_CSUM_EN
          csum_d = csum_q ^ ser_data;
`endif
          if (ser_last) begin
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q != CNT_W'(1)) begin
              state_d = READ;
            end else begin
`ifdef X_SCOPE_DUMP_CSUM_EN
              state_d = CSUM;
`else
              state_d = DONE;
`endif
            end
          end
        end
      end
`ifdef X_SCOPE_DUMP_CSUM_EN
      CSUM: begin
        if (i_tx_accept) begin
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; asynchronous reset aborts a dump without a completion pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
`ifdef X_SCOPE_DUMP_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
`ifdef X_SCOPE_DUMP_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign o_busy  = (state_q != IDLE) && (state_q != DONE);
  assign o_done  = (state_q == DONE);
  assign o_ren   = (state_q == READ) && (cnt_q != '0);
  assign o_raddr = addr_q;

`ifdef X_SCOPE_DUMP_CSUM_EN
  assign o_tx_valid = ser_valid || (state_q == CSUM);
  assign o_tx_data  = (state_q == CSUM) ? csum_q : ser_data;
`else
  assign o_tx_valid = ser_valid;
  assign o_tx_data  = ser_data;
`endif

endmodule
`default_nettype wire
